dsp_post_adder: RTL and testbench

DSP_POST_ADDER -- requirements
Module: dsp_post_adder

---
 rtl/dsp_pkg.sv | 31 +++
 rtl/dsp_reg_async.sv | 26 ++
 rtl/dsp_post_adder.sv | 129 ++++++++++++
 tb/tb_dsp_post_adder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared constants for the DSP post-adder: X/Z mux encodings, opmode bit
// positions, default datapath width and a signed-overflow helper.
package dsp_pkg;

  localparam int DSP_WIDTH    = 48;
  localparam int M_WIDTH      = 36;
  localparam int OPMODE_WIDTH = 8;

  localparam logic [1:0] X_ZERO = 2'd0;
  localparam logic [1:0] X_M    = 2'd1;
  localparam logic [1:0] X_P    = 2'd2;
  localparam logic [1:0] X_DAB  = 2'd3;

  localparam logic [1:0] Z_ZERO = 2'd0;
  localparam logic [1:0] Z_PCIN = 2'd1;
  localparam logic [1:0] Z_P    = 2'd2;
  localparam logic [1:0] Z_C    = 2'd3;

  localparam int OPM_X_LSB   = 0;
  localparam int OPM_Z_LSB   = 2;
  localparam int OPM_SUB_BIT = 7;

  // Subtraction behaves like Z + ~X, so the X sign is effectively inverted.
  function automatic logic signed_ovf(input logic z_msb, input logic x_msb,
                                      input logic r_msb, input logic sub);
    logic x_eff;
    x_eff = sub ? ~x_msb : x_msb;
    return (z_msb == x_eff) && (r_msb != z_msb);
  endfunction

endpackage

// File: rtl/dsp_reg_async.sv
// Enabled register with asynchronous active-low clear and a static bypass
// option that turns it into a wire.
module dsp_reg_async #(
  parameter int W      = 1,
  parameter bit BYPASS = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r <= '0;
    end else if (en) begin
      q_r <= d;
    end
  end

  assign q = BYPASS ? d : q_r;

endmodule

// File: rtl/dsp_post_adder.sv
// DSP48-style post-adder/subtractor with X/Z operand muxes and P feedback.
// Optional sticky signed-overflow flag under DSP_POST_ADDER_OVF_EN.
module dsp_post_adder
  import dsp_pkg::*;
#(
  parameter int PREG      = 1,
  parameter int OPMODEREG = 1,
  parameter int WIDTH     = DSP_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [M_WIDTH-1:0]      m,
  input  logic [WIDTH-1:0]        dab,
  input  logic [WIDTH-1:0]        c,
  input  logic [WIDTH-1:0]        pcin,
  input  logic [OPMODE_WIDTH-1:0] opmode,
  input  logic                    carryin,
  input  logic                    ce_opmode,
  input  logic                    cep,
  input  logic                    in_valid,
`ifdef DSP_POST_ADDER_OVF_EN
  input  logic                    ovf_clr,
  output logic                    ovf,
`endif
  output logic [WIDTH-1:0]        p,
  output logic [WIDTH-1:0]        pcout,
  output logic                    carryout,
  output logic                    out_valid
);

  logic [OPMODE_WIDTH-1:0] opm;
  logic [WIDTH-1:0]        p_q;
  logic [WIDTH-1:0]        p_fb;
  logic                    co_q;
  logic [WIDTH-1:0]        x_val;
  logic [WIDTH-1:0]        z_val;
  logic [WIDTH:0]          sum_ext;
  logic                    sub;
  logic [2:0]              unused_opm_bits;

  dsp_reg_async #(.W(OPMODE_WIDTH), .BYPASS(OPMODEREG == 0)) u_opmode_reg (
    .clk (clk),
    .rst (rst),
    .en  (ce_opmode),
    .d   (opmode),
    .q   (opm)
  );

  assign sub             = opm[OPM_SUB_BIT];
  assign unused_opm_bits = opm[6:4];

  // Without a P register the feedback path is tied off to avoid a loop.
  assign p_fb = (PREG != 0) ? p_q : '0;

  always_comb begin
    x_val = '0;
    case (opm[OPM_X_LSB +: 2])
      X_ZERO:  x_val = '0;
      X_M:     x_val = {{(WIDTH-M_WIDTH){1'b0}}, m};
      X_P:     x_val = p_fb;
      X_DAB:   x_val = dab;
      default: x_val = '0;
    endcase
  end

  always_comb begin
    z_val = '0;
    case (opm[OPM_Z_LSB +: 2])
      Z_ZERO:  z_val = '0;
      Z_PCIN:  z_val = pcin;
      Z_P:     z_val = p_fb;
      Z_C:     z_val = c;
      default: z_val = '0;
    endcase
  end

  // Bit WIDTH is the carry on add and the borrow on subtract.
  always_comb begin
    sum_ext = '0;
    if (sub) begin
      sum_ext = {1'b0, z_val} - ({1'b0, x_val} + {{WIDTH{1'b0}}, carryin});
    end else begin
      sum_ext = {1'b0, z_val} + {1'b0, x_val} + {{WIDTH{1'b0}}, carryin};
    end
  end

  dsp_reg_async #(.W(WIDTH + 1), .BYPASS(PREG == 0)) u_p_reg (
    .clk (clk),
    .rst (rst),
    .en  (cep),
    .d   (sum_ext),
    .q   ({co_q, p_q})
  );

  dsp_reg_async #(.W(1), .BYPASS(PREG == 0)) u_valid_reg (
    .clk (clk),
    .rst (rst),
    .en  (cep),
    .d   (in_valid),
    .q   (out_valid)
  );

  assign p        = p_q;
  assign pcout    = p_q;
  assign carryout = co_q;

`ifdef DSP_POST_ADDER_OVF_EN
  logic p_load;
  logic ovf_set;
  logic ovf_q;

  assign p_load  = (PREG != 0) ? cep : 1'b1;
  assign ovf_set = p_load &
                   signed_ovf(z_val[WIDTH-1], x_val[WIDTH-1], sum_ext[WIDTH-1], sub);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_dsp_post_adder.sv
// Directed bench for dsp_post_adder: arithmetic reference model compared on
// every falling edge, plus hand-computed literal expectations.
module tb_dsp_post_adder;

  logic        clk;
  logic        rst;
  logic [35:0] m;
  logic [47:0] dab, c, pcin;
  logic [7:0]  opmode;
  logic        carryin, ce_opmode, cep, in_valid;
  logic [47:0] p, pcout;
  logic        carryout, out_valid;
`ifdef DSP_POST_ADDER_OVF_EN
  logic        ovf_clr, ovf;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  dsp_post_adder dut (
    .clk       (clk),
    .rst       (rst),
    .m         (m),
    .dab       (dab),
    .c         (c),
    .pcin      (pcin),
    .opmode    (opmode),
    .carryin   (carryin),
    .ce_opmode (ce_opmode),
    .cep       (cep),
    .in_valid  (in_valid),
`ifdef DSP_POST_ADDER_OVF_EN
    .ovf_clr   (ovf_clr),
    .ovf       (ovf),
`endif
    .p         (p),
    .pcout     (pcout),
    .carryout  (carryout),
    .out_valid (out_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: plain 64-bit arithmetic on the selected operands
  logic [47:0] mp;
  logic        mco, mvalid, movf;
  logic [7:0]  mopm;

  function automatic longint unsigned pick(input logic [1:0] sel, input bit is_x);
    if (sel == 2'd0) return 64'd0;
    if (sel == 2'd2) return 64'(mp);
    if (is_x) return (sel == 2'd1) ? 64'(m) : 64'(dab);
    return (sel == 2'd1) ? 64'(pcin) : 64'(c);
  endfunction

  function automatic void model_calc(output logic [47:0] np, output logic nco,
                                     output logic nov);
    longint unsigned xv, zv, r;
    longint sx, sz, sr, ci;
    xv = pick(mopm[1:0], 1'b1);
    zv = pick(mopm[3:2], 1'b0);
    ci = carryin ? 64'sd1 : 64'sd0;
    if (!mopm[7]) begin
      r   = zv + xv + 64'(carryin);
      np  = r[47:0];
      nco = r[48];
    end else begin
      r   = zv - xv - 64'(carryin);
      np  = r[47:0];
      nco = (zv < xv + 64'(carryin));
    end
    sx  = longint'($signed(xv[47:0]));
    sz  = longint'($signed(zv[47:0]));
    sr  = mopm[7] ? (sz - sx - ci) : (sz + sx + ci);
    nov = (sr > 64'sh7FFF_FFFF_FFFF) || (sr < -64'sh8000_0000_0000);
  endfunction

  always @(posedge clk or negedge rst) begin
    logic [47:0] np;
    logic        nco, nov;
    if (!rst) begin
      mp <= '0; mco <= 1'b0; mvalid <= 1'b0; movf <= 1'b0; mopm <= '0;
    end else begin
      model_calc(np, nco, nov);
      if (cep) begin
        mp <= np; mco <= nco; mvalid <= in_valid;
      end
`ifdef DSP_POST_ADDER_OVF_EN
      if (cep && nov) movf <= 1'b1;
      else if (ovf_clr) movf <= 1'b0;
`endif
      if (ce_opmode) mopm <= opmode;
    end
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_p(input string tag, input logic [47:0] ep, input logic eco);
    check({tag, " p"}, 64'(p), 64'(ep));
    check({tag, " carryout"}, 64'(carryout), 64'(eco));
    check({tag, " model p"}, 64'(mp), 64'(ep));
    check({tag, " model carryout"}, 64'(mco), 64'(eco));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp p", 64'(p), 64'(mp));
      check("cmp pcout", 64'(pcout), 64'(mp));
      check("cmp carryout", 64'(carryout), 64'(mco));
      check("cmp out_valid", 64'(out_valid), 64'(mvalid));
`ifdef DSP_POST_ADDER_OVF_EN
      check("cmp ovf", 64'(ovf), 64'(movf));
`endif
    end
  end

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_opmode(input logic [7:0] op);
    opmode = op; ce_opmode = 1'b1; cep = 1'b0;
    cycle();
    ce_opmode = 1'b0;
  endtask

  initial begin
    rst = 1'b1; m = '0; dab = '0; c = '0; pcin = '0; opmode = '0;
    carryin = 1'b0; ce_opmode = 1'b0; cep = 1'b0; in_valid = 1'b0;
`ifdef DSP_POST_ADDER_OVF_EN
    ovf_clr = 1'b0;
`endif
    #1 rst = 1'b0;
    #1;
    expect_p("reset", 48'd0, 1'b0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    cmp_en = 1'b1;
    cycle(); cycle();
    rst = 1'b1;

    // c + m + carryin
    load_opmode(8'h0D);
    c = 48'd100; m = 36'd25; carryin = 1'b1; cep = 1'b1; in_valid = 1'b1;
    cycle();
    expect_p("add", 48'd126, 1'b0);
    check("add out_valid", 64'(out_valid), 64'd1);

    // opmode and cep on the same edge: P uses the old opmode
    opmode = 8'h8D; ce_opmode = 1'b1; c = 48'd10; m = 36'd25; carryin = 1'b0;
    cycle();
    expect_p("same edge", 48'd35, 1'b0);
    ce_opmode = 1'b0;
    cycle();
    expect_p("sub borrow", 48'hFFFF_FFFF_FFF1, 1'b1);

    // preload P, then accumulate across the wrap
    c = 48'hFFFF_FFFF_FFF0; m = 36'd0; opmode = 8'h09; ce_opmode = 1'b1;
    cycle();
    expect_p("preload", 48'hFFFF_FFFF_FFF0, 1'b0);
    ce_opmode = 1'b0; m = 36'd16;
    cycle();
    expect_p("acc wrap", 48'd0, 1'b1);
    m = 36'd3;
    cycle();
    expect_p("acc next", 48'd3, 1'b0);

    // hold with cep=0; opmode change without ce_opmode is ignored
    cep = 1'b0; in_valid = 1'b0; opmode = 8'h0D;
    for (int i = 0; i < 5; i++) begin
      m = (i % 2 == 0) ? 36'hF_FFFF_FFFF : 36'd7;
      cycle();
      check("hold p", 64'(p), 64'd3);
      check("hold out_valid", 64'(out_valid), 64'd1);
    end
    cep = 1'b1; in_valid = 1'b1; m = 36'd4;
    cycle();
    expect_p("opmode kept", 48'd7, 1'b0);
    in_valid = 1'b0; m = 36'd1;
    cycle();
    expect_p("acc invalid", 48'd8, 1'b0);
    check("valid drop", 64'(out_valid), 64'd0);

    // asynchronous reset mid-accumulation
    in_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    expect_p("async reset", 48'd0, 1'b0);
    check("async reset out_valid", 64'(out_valid), 64'd0);
    cycle();
    rst = 1'b1;
    load_opmode(8'h09);
    cep = 1'b1; m = 36'd5;
    cycle();
    expect_p("post reset acc", 48'd5, 1'b0);

    // dab + pcin + carryin
    load_opmode(8'h07);
    cep = 1'b1; pcin = 48'd1000; dab = 48'd1; carryin = 1'b1;
    cycle();
    expect_p("dab pcin", 48'd1002, 1'b0);

    // c - (dab + carryin) underflow to all ones
    load_opmode(8'h8F);
    cep = 1'b1; c = 48'd5; dab = 48'd5; carryin = 1'b1;
    cycle();
    expect_p("sub all ones", 48'hFFFF_FFFF_FFFF, 1'b1);

    // P + P
    load_opmode(8'h0A);
    cep = 1'b1; carryin = 1'b0;
    cycle();
    expect_p("p plus p", 48'hFFFF_FFFF_FFFE, 1'b1);

`ifdef DSP_POST_ADDER_OVF_EN
    load_opmode(8'h0D);
    check("ovf idle", 64'(ovf), 64'd0);
    cep = 1'b1; c = 48'h7FFF_FFFF_FFFF; m = 36'd1; carryin = 1'b0;
    cycle();
    expect_p("ovf add", 48'h8000_0000_0000, 1'b0);
    check("ovf set", 64'(ovf), 64'd1);
    c = 48'd0; m = 36'd0;
    cycle();
    check("ovf sticky", 64'(ovf), 64'd1);
    ovf_clr = 1'b1;
    cycle();
    check("ovf clear", 64'(ovf), 64'd0);
    c = 48'h7FFF_FFFF_FFFF; m = 36'd1;
    cycle();
    check("ovf set wins", 64'(ovf), 64'd1);
    ovf_clr = 1'b0;
`endif

    cep = 1'b0;
    cycle(); cycle();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
